// File: rtl/token_matcher_pkg.sv
// rtl/token_matcher_pkg.sv - shared types and helpers for the vocab token matcher
package token_matcher_pkg;

  localparam int CHAR_W   = 8;
  localparam int WORD_LEN = 8;
  localparam int CI_W     = $clog2(WORD_LEN + 1);

  localparam logic [CHAR_W-1:0] NUL = '0;

  typedef enum logic [1:0] {IDLE, MATCH, SKIP, DONE} state_e;

  // Characters past the packed word read as NUL so over-long entries never match exactly.
  function automatic logic [CHAR_W-1:0] char_at(input logic [WORD_LEN*CHAR_W-1:0] word,
                                                input logic [CI_W-1:0]            ci);
    if (ci >= CI_W'(WORD_LEN)) return NUL;
    return word[ci*CHAR_W +: CHAR_W];
  endfunction

endpackage

// File: rtl/token_matcher.sv
// rtl/token_matcher.sv - scans a NUL-terminated vocab list in SRAM and returns the matching token index
module token_matcher
  import token_matcher_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = CHAR_W,
  parameter int MAX_WORD_LEN = WORD_LEN,
  parameter int ID_WIDTH     = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               abort,
  input  logic                               prefix_mode,
  input  logic [MAX_WORD_LEN*DATA_WIDTH-1:0] word,
  input  logic [ADDR_WIDTH-1:0]              base_addr,
  input  logic [ADDR_WIDTH:0]                end_addr,
  output logic                               mem_rd_en,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  input  logic [DATA_WIDTH-1:0]              mem_rdata,
  output logic                               busy,
  output logic                               done,
  output logic                               found,
  output logic [ID_WIDTH-1:0]                token_id,
  output logic [ADDR_WIDTH-1:0]              match_addr
);

  state_e                             state_q, state_d;
  logic [MAX_WORD_LEN*DATA_WIDTH-1:0] word_q;
  logic                               prefix_q;
  logic [ADDR_WIDTH:0]                end_q;
  logic [ADDR_WIDTH:0]                rd_q;
  logic [ADDR_WIDTH:0]                p_q;
  logic                               rvalid_q;
  logic [CI_W-1:0]                    ci_q, ci_d;
  logic [ID_WIDTH-1:0]                tok_q, tok_d;
  logic [ADDR_WIDTH-1:0]              entry_q, entry_d;
  logic                               found_q, found_d;
  logic [ADDR_WIDTH-1:0]              maddr_q, maddr_d;

  logic                  scan, accept, fin_nf, fin_hit, next_entry;
  logic [DATA_WIDTH-1:0] v, w;

  assign scan = (state_q == MATCH) || (state_q == SKIP);
  assign v    = mem_rdata;
  assign w    = char_at(word_q, ci_q);

  always_comb begin
    state_d    = state_q;
    ci_d       = ci_q;
    tok_d      = tok_q;
    entry_d    = entry_q;
    found_d    = found_q;
    maddr_d    = maddr_q;
    accept     = 1'b0;
    fin_nf     = 1'b0;
    fin_hit    = 1'b0;
    next_entry = 1'b0;

    case (state_q)
      MATCH: begin
        if (abort) begin
          state_d = IDLE;
        end else if (rvalid_q) begin
          if (p_q == end_q || (v == NUL && ci_q == '0)) fin_nf = 1'b1;
          else if (w == NUL && (v == NUL || prefix_q))   fin_hit = 1'b1;
          else if (v == w)                               ci_d = ci_q + 1'b1;
          else if (v == NUL)                             next_entry = 1'b1;
          else                                           state_d = SKIP;
        end
      end
      SKIP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (rvalid_q) begin
          if (p_q == end_q)  fin_nf = 1'b1;
          else if (v == NUL) next_entry = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase

    // A full token counter ends the scan instead of wrapping back to entry 0.
    if (next_entry) begin
      if (&tok_q) begin
        fin_nf = 1'b1;
      end else begin
        tok_d   = tok_q + 1'b1;
        entry_d = p_q[ADDR_WIDTH-1:0] + 1'b1;
        ci_d    = '0;
        state_d = MATCH;
      end
    end

    if (fin_nf || fin_hit) begin
      state_d = DONE;
      found_d = fin_hit;
      maddr_d = entry_q;
    end

    if ((state_q == IDLE || state_q == DONE) && start && !abort) begin
      accept  = 1'b1;
      found_d = 1'b0;
      tok_d   = '0;
      ci_d    = '0;
      entry_d = base_addr;
      if (word[DATA_WIDTH-1:0] == NUL) begin
        state_d = DONE;
        maddr_d = base_addr;
      end else begin
        state_d = MATCH;
      end
    end
  end

  // rd_q runs one address ahead of p_q, the address of the byte currently on mem_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      word_q   <= '0;
      prefix_q <= 1'b0;
      end_q    <= '0;
      rd_q     <= '0;
      p_q      <= '0;
      rvalid_q <= 1'b0;
      ci_q     <= '0;
      tok_q    <= '0;
      entry_q  <= '0;
      found_q  <= 1'b0;
      maddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      ci_q     <= ci_d;
      tok_q    <= tok_d;
      entry_q  <= entry_d;
      found_q  <= found_d;
      maddr_q  <= maddr_d;
      p_q      <= rd_q;
      rvalid_q <= scan;
      if (accept) begin
        word_q   <= word;
        prefix_q <= prefix_mode;
        end_q    <= end_addr;
        rd_q     <= {1'b0, base_addr};
      end else if (scan) begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end

  assign mem_rd_en  = scan;
  assign mem_addr   = rd_q[ADDR_WIDTH-1:0];
  assign busy       = scan;
  assign done       = (state_q == DONE);
  assign found      = found_q;
  assign token_id   = tok_q;
  assign match_addr = maddr_q;

endmodule

// File: tb/tb_token_matcher.sv
// tb/tb_token_matcher.sv - scoreboard bench for token_matcher
module tb_token_matcher;

  typedef struct {int found; int tok; int maddr; int lat;} exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start2 = 1'b0, abort = 1'b0, prefix_mode = 1'b0;
  logic [63:0] word = '0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  end_addr = '0;

  logic       rd1, busy1, done1, found1;
  logic [7:0] addr1, rdata1 = '0, token1, maddr1;
  logic       rd2, busy2, done2, found2;
  logic [7:0] addr2, rdata2 = '0, maddr2;
  logic [1:0] token2;

  logic [7:0] mem [0:255];
  exp_t q1[$], q2[$];
  int checks = 0, errors = 0;
  int cyc = 0, s1 = 0, s2 = 0, n1 = 0, n2 = 0;
  int done1_cnt = 0, done2_cnt = 0, reads1 = 0;

  token_matcher dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .prefix_mode(prefix_mode),
    .word(word), .base_addr(base_addr), .end_addr(end_addr), .mem_rd_en(rd1),
    .mem_addr(addr1), .mem_rdata(rdata1), .busy(busy1), .done(done1), .found(found1),
    .token_id(token1), .match_addr(maddr1)
  );

  token_matcher #(.ID_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .prefix_mode(prefix_mode),
    .word(word), .base_addr(base_addr), .end_addr(end_addr), .mem_rd_en(rd2),
    .mem_addr(addr2), .mem_rdata(rdata2), .busy(busy2), .done(done2), .found(found2),
    .token_id(token2), .match_addr(maddr2)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rd1) rdata1 <= mem[addr1];
    if (rd2) rdata2 <= mem[addr2];
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin : mon1
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd1) reads1++;
      if (done1) begin
        done1_cnt++;
        if (q1.size() == 0) check("spurious_done", 1, 0);
        else begin
          e = q1.pop_front();
          check("found", int'(found1), e.found);
          check("token_id", int'(token1), e.tok);
          if (e.maddr >= 0) check("match_addr", int'(maddr1), e.maddr);
          if (e.lat >= 0) check("latency", cyc - s1, e.lat);
        end
      end
    end
  end

  initial begin : mon2
    exp_t e;
    forever begin
      @(negedge clk);
      if (done2) begin
        done2_cnt++;
        if (q2.size() == 0) check("sat_spurious_done", 1, 0);
        else begin
          e = q2.pop_front();
          check("sat_found", int'(found2), e.found);
          check("sat_token_id", int'(token2), e.tok);
          check("sat_latency", cyc - s2, e.lat);
        end
      end
    end
  end

  function automatic logic [63:0] pack(input string s);
    logic [63:0] r = '0;
    for (int i = 0; i < s.len() && i < 8; i++) r[i*8 +: 8] = s[i];
    return r;
  endfunction

  task automatic put(input int a, input string s);
    for (int i = 0; i < s.len(); i++) mem[a+i] = s[i];
  endtask

  task automatic go1(input string w, input bit pm, input int e_addr, input bit push,
                     input int ef, input int et, input int em, input int el);
    exp_t e;
    e = '{ef, et, em, el};
    @(negedge clk);
    word = pack(w); prefix_mode = pm; base_addr = 8'd0; end_addr = e_addr[8:0];
    start = 1'b1;
    s1 = cyc;
    n1 = done1_cnt;
    if (push) q1.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait1();
    int k;
    for (k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (done1_cnt != n1) break;
    end
    if (k == 200) begin
      check("timeout", 0, 1);
      q1.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    put(0, "cat"); put(4, "dog"); put(8, "do");
    put(32, "a"); put(34, "b"); put(36, "c"); put(38, "d"); put(40, "e");

    repeat (3) @(negedge clk);
    check("rst_done", int'(done1), 0);
    check("rst_busy", int'(busy1), 0);
    check("rst_rd_en", int'(rd1), 0);
    check("rst_outs", int'({found1, token1, maddr1, addr1}), 0);
    rst_n = 1'b1;

    go1("do", 0, 16, 1, 1, 2, 8, 13);  wait1();
    repeat (4) @(negedge clk);
    check("hold_found", int'(found1), 1);
    check("hold_token", int'(token1), 2);
    go1("do", 1, 16, 1, 1, 1, 4, 9);   wait1();
    go1("cow", 0, 16, 1, 0, 3, 11, 14); wait1();
    go1("dog", 0, 6, 1, 0, 1, 4, -1);  wait1();
    go1("cat", 0, 16, 1, 1, 0, 0, 6);  wait1();
    go1("c", 1, 16, 1, 1, 0, 0, 4);    wait1();
    go1("dog", 0, 16, 1, 1, 1, 4, 10); wait1();

    begin
      int r0;
      r0 = reads1;
      go1("", 0, 16, 1, 0, 0, 0, 1);   wait1();
      check("empty_no_reads", reads1 - r0, 0);
    end

    go1("do", 0, 16, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_busy", int'(busy1), 0);
    check("abort_no_done", done1_cnt - n1, 0);
    go1("do", 0, 16, 1, 1, 2, 8, 13);  wait1();

    go1("zz", 0, 16, 0, 0, 0, 0, 0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy1), 0);
    check("midrst_rd_en", int'(rd1), 0);
    check("midrst_token", int'(token1), 0);
    check("midrst_maddr", int'(maddr1), 0);
    check("midrst_addr", int'(addr1), 0);
    @(negedge clk);
    rst_n = 1'b1;

    go1("do", 0, 16, 1, 1, 2, 8, 13);
    repeat (2) @(negedge clk);
    word = pack("cat"); prefix_mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait1();

    @(negedge clk);
    word = pack("z"); prefix_mode = 1'b0; base_addr = 8'd32; end_addr = 9'd64;
    start2 = 1'b1;
    s2 = cyc;
    n2 = done2_cnt;
    q2.push_back('{0, 3, -1, 10});
    @(negedge clk);
    start2 = 1'b0;
    begin
      int k;
      for (k = 0; k < 200; k++) begin
        @(posedge clk);
        #1;
        if (done2_cnt != n2) break;
      end
      if (k == 200) check("sat_timeout", 0, 1);
    end

    repeat (5) @(negedge clk);
    check("queue1_empty", q1.size(), 0);
    check("queue2_empty", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
